// File: rtl/grf_scoreboard.sv
// grf_scoreboard: general register file with write-through forwarding and a
// per-register pending-write scoreboard used by the decode hazard unit.
// Optional build macro GRF_TRACE_EN: prints one trace line per accepted write.
module grf_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_busy,
    input  logic                         claim_en,
    input  logic [ADDR_W-1:0]            claim_addr,
    output logic                         claim_ovf,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic [31:0]                  wb_pc,
    input  logic                         flush
);

    localparam int unsigned      DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_d  [DEPTH];
    logic              ovf_q, ovf_d;

    logic claim_ok, wb_ok;

    // Register 0 is hard-wired: claims and writes to it are simply not accepted.
    assign claim_ok = claim_en && (claim_addr != '0);
    assign wb_ok    = wb_en && (wb_addr != '0);

`ifndef GRF_TRACE_EN
    logic unused_wb_pc;
    assign unused_wb_pc = ^wb_pc;
`endif

    // Data array: cleared on reset, written by the writeback port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_ok) begin
            regs_q[wb_addr] <= wb_data;
`ifdef GRF_TRACE_EN
            $display("@%08h: $%02d <= %h", wb_pc, wb_addr, wb_data);
`endif
        end
    end

    // Pending counters next state: flush, then same-address cancel, then claim/wb.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_d[i] = '0;
            end
        end else if (!(claim_ok && wb_ok && (claim_addr == wb_addr))) begin
            if (claim_ok) begin
                if (cnt_q[claim_addr] != CNT_MAX) begin
                    cnt_d[claim_addr] = cnt_q[claim_addr] + CNT_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if (wb_ok && (cnt_q[wb_addr] != '0)) begin
                cnt_d[wb_addr] = cnt_q[wb_addr] - CNT_ONE;
            end
        end
    end

    // Pending counters and overflow pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign claim_ovf = ovf_q;

    // Read ports: forwarding from writeback, busy released by the last pending write.
    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              fwd;
        logic              zero;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign fwd  = wb_en && (wb_addr == addr);
        // Reads are held at 0 while reset is asserted so the cleared state is
        // visible immediately, even if writeback is still driving.
        assign zero = reset || (addr == '0);

        assign rd_data[k*DATA_W +: DATA_W] = zero ? '0 :
                                             fwd  ? wb_data : regs_q[addr];
        assign rd_busy[k] = !zero && (cnt_q[addr] != '0) &&
                            !(fwd && (cnt_q[addr] == CNT_ONE));
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: scoreboard-style bench for grf_scoreboard (default
// configuration plus a 64-bit / 16-entry / 3-port instance).
module tb_grf_scoreboard;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        claim_ovf;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        flush;

    // Wide instance
    logic [11:0]  w_rd_addr;
    logic [191:0] w_rd_data;
    logic [2:0]   w_rd_busy;
    logic         w_claim_en;
    logic [3:0]   w_claim_addr;
    logic         w_claim_ovf;
    logic         w_wb_en;
    logic [3:0]   w_wb_addr;
    logic [63:0]  w_wb_data;
    logic [31:0]  w_wb_pc;
    logic         w_flush;

    grf_scoreboard u_dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .claim_ovf  (claim_ovf),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_pc      (wb_pc),
        .flush      (flush)
    );

    grf_scoreboard #(
        .DATA_W   (64),
        .ADDR_W   (4),
        .RD_PORTS (3),
        .CNT_W    (2)
    ) u_wide (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (w_rd_addr),
        .rd_data    (w_rd_data),
        .rd_busy    (w_rd_busy),
        .claim_en   (w_claim_en),
        .claim_addr (w_claim_addr),
        .claim_ovf  (w_claim_ovf),
        .wb_en      (w_wb_en),
        .wb_addr    (w_wb_addr),
        .wb_data    (w_wb_data),
        .wb_pc      (w_wb_pc),
        .flush      (w_flush)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Observation points selectable by scoreboard entries
    localparam int D0 = 0, D1 = 1, B0 = 2, B1 = 3, OVF = 4;
    localparam int WD0 = 5, WD1 = 6, WD2 = 7, WBUSY = 8, WOVF = 9;

    function automatic logic [63:0] observe(input int sel);
        logic [63:0] v;
        v = '0;
        case (sel)
            D0:      v = {32'h0, rd_data[31:0]};
            D1:      v = {32'h0, rd_data[63:32]};
            B0:      v = {63'h0, rd_busy[0]};
            B1:      v = {63'h0, rd_busy[1]};
            OVF:     v = {63'h0, claim_ovf};
            WD0:     v = w_rd_data[63:0];
            WD1:     v = w_rd_data[127:64];
            WD2:     v = w_rd_data[191:128];
            WBUSY:   v = {61'h0, w_rd_busy};
            WOVF:    v = {63'h0, w_claim_ovf};
            default: v = '1;
        endcase
        return v;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then drain the scoreboard
    task automatic settle_check();
        exp_t e;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        claim_en = 1'b0; wb_en = 1'b0; flush = 1'b0;
        w_claim_en = 1'b0; w_wb_en = 1'b0; w_flush = 1'b0;
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d; wb_pc = 32'h0000_1000 + {25'h0, a, 2'b00};
    endtask

    task automatic do_claim(input logic [4:0] a);
        claim_en = 1'b1; claim_addr = a;
    endtask

    task automatic w_wb(input logic [3:0] a, input logic [63:0] d);
        w_wb_en = 1'b1; w_wb_addr = a; w_wb_data = d; w_wb_pc = 32'h0000_2000;
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = '0; claim_addr = '0; wb_addr = '0; wb_data = '0; wb_pc = '0;
        w_rd_addr = '0; w_claim_addr = '0; w_wb_addr = '0; w_wb_data = '0; w_wb_pc = '0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        rd_addr = {5'd7, 5'd5};
        push("rst_d0", D0, 0); push("rst_d1", D1, 0);
        push("rst_b0", B0, 0); push("rst_b1", B1, 0); push("rst_ovf", OVF, 0);
        settle_check();

        // Forwarding
        do_wb(5, 32'h1111_1111); tick();
        idle(); rd_addr = {5'd5, 5'd0};
        push("fwd_old", D1, 64'h1111_1111); push("fwd_r0", D0, 0);
        settle_check();
        do_wb(5, 32'hDEAD_BEEF);
        push("fwd_same", D1, 64'hDEAD_BEEF);
        settle_check();
        tick(); idle();
        push("fwd_later", D1, 64'hDEAD_BEEF);
        settle_check();

        // Scoreboard release
        do_claim(7); tick(); do_claim(7); tick(); idle();
        rd_addr = {5'd0, 5'd7};
        push("rel_busy2", B0, 1);
        settle_check();
        do_wb(7, 32'hA5A5_A5A5);
        push("rel_wb1_busy", B0, 1); push("rel_wb1_data", D0, 64'hA5A5_A5A5);
        settle_check();
        tick(); do_wb(7, 32'h5A5A_5A5A);
        push("rel_wb2_busy", B0, 0); push("rel_wb2_data", D0, 64'h5A5A_5A5A);
        settle_check();
        tick(); idle();
        push("rel_after_busy", B0, 0); push("rel_after_data", D0, 64'h5A5A_5A5A);
        settle_check();

        // Saturation
        rd_addr = {5'd0, 5'd9};
        for (int i = 0; i < 3; i++) begin
            do_claim(9); tick();
        end
        do_claim(9);
        push("sat_ovf_pre", OVF, 0); push("sat_busy", B0, 1);
        settle_check();
        tick(); idle();
        push("sat_ovf_pulse", OVF, 1);
        settle_check();
        tick();
        push("sat_ovf_clear", OVF, 0);
        settle_check();
        for (int i = 0; i < 3; i++) begin
            do_wb(9, 32'h0000_0990 + i);
            push("sat_wb_busy", B0, (i == 2) ? 64'd0 : 64'd1);
            settle_check();
            tick();
        end
        idle();
        push("sat_done_busy", B0, 0); push("sat_done_data", D0, 64'h0000_0992);
        settle_check();

        // Simultaneous events
        rd_addr = {5'd4, 5'd3};
        do_claim(3); tick(); idle();
        push("sim_busy1", B0, 1);
        settle_check();
        do_claim(3); do_wb(3, 32'h0000_0033);
        push("sim_cw_busy", B0, 0); push("sim_cw_data", D0, 64'h33);
        settle_check();
        tick(); idle();
        push("sim_cw_keep", B0, 1);
        settle_check();
        flush = 1'b1; do_claim(4); do_wb(3, 32'h0000_0044);
        tick(); idle();
        push("flush_b0", B0, 0); push("flush_b1", B1, 0); push("flush_data", D0, 64'h44);
        settle_check();

        // No underflow: wb with cnt==0 writes data, counter stays 0
        do_wb(3, 32'h0000_0055); tick(); idle();
        push("uf_data", D0, 64'h55);
        settle_check();
        do_claim(3); tick(); idle();
        push("uf_claim_busy", B0, 1);
        settle_check();
        do_wb(3, 32'h0000_0066);
        push("uf_release", B0, 0); push("uf_fwd", D0, 64'h66);
        settle_check();
        tick(); idle();

        // Register 0
        rd_addr = {5'd0, 5'd0};
        do_wb(0, 32'hFFFF_FFFF); do_claim(0);
        push("r0_d0", D0, 0); push("r0_d1", D1, 0); push("r0_b0", B0, 0); push("r0_b1", B1, 0);
        settle_check();
        tick(); idle();
        push("r0_ovf", OVF, 0); push("r0_after_d0", D0, 0); push("r0_after_b0", B0, 0);
        settle_check();

        // Asynchronous reset mid-run with pending claims and an ovf pulse
        rd_addr = {5'd5, 5'd12};
        for (int i = 0; i < 4; i++) begin
            do_claim(12); tick();
        end
        idle();
        push("pre_rst_ovf", OVF, 1); push("pre_rst_busy", B0, 1); push("pre_rst_d1", D1, 64'hDEAD_BEEF);
        settle_check();
        reset = 1'b1;
        #1;
        push("arst_d0", D0, 0); push("arst_d1", D1, 0);
        push("arst_b0", B0, 0); push("arst_b1", B1, 0); push("arst_ovf", OVF, 0);
        settle_check();
        tick(); reset = 1'b0;
        push("post_rst_d1", D1, 0); push("post_rst_b0", B0, 0);
        settle_check();

        // Wide configuration forwarding
        w_rd_addr = {4'd5, 4'd0, 4'd5};
        w_wb(5, 64'h1111_1111_1111_1111); tick(); idle();
        push("w_old", WD2, 64'h1111_1111_1111_1111);
        settle_check();
        w_wb(5, 64'hDEAD_BEEF_CAFE_F00D);
        push("w_fwd_p0", WD0, 64'hDEAD_BEEF_CAFE_F00D); push("w_fwd_p1", WD1, 0);
        push("w_fwd_p2", WD2, 64'hDEAD_BEEF_CAFE_F00D); push("w_busy", WBUSY, 0);
        settle_check();
        tick(); idle();
        push("w_later_p0", WD0, 64'hDEAD_BEEF_CAFE_F00D); push("w_later_p2", WD2, 64'hDEAD_BEEF_CAFE_F00D);
        settle_check();
        w_rd_addr = {4'd5, 4'd6, 4'd5};
        w_claim_en = 1'b1; w_claim_addr = 4'd6; tick(); idle();
        push("w_claim_busy", WBUSY, 64'b010); push("w_ovf", WOVF, 0);
        settle_check();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
